// File: rtl/bcd_seconds_pkg.sv
// +----------------------------------------------------------------------+
// | bcd_seconds_pkg: shared types and helpers for the BCD seconds counter  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package bcd_seconds_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  // Binary value of a two-digit BCD pair; 8 bits covers 15*10+15 for illegal digits.
  function automatic logic [7:0] bcd_value(input bcd_digit_t tens, input bcd_digit_t units);
    return ({4'd0, tens} * 8'd10) + {4'd0, units};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_seconds_counter_prescaler.sv
// +----------------------------------------------------------------------+
// | tick_prescaler: divides clk by DIV, flags the terminal count cycle     |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] C_LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == C_LAST);
  // Combinational so the parent can register digits and tick on the same edge.
  assign tick   = enable & ~clear & w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_seconds_counter.sv
// +----------------------------------------------------------------------+
// | bcd_seconds_counter: two-digit BCD up/down seconds counter with        |
// | start/stop, clear and clamped parallel load.                           |
// | Optional: BCD_SECONDS_AUTO_STOP_EN stops at 00 when counting down.     |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_seconds_counter
  import bcd_seconds_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1,
  parameter int MAX_COUNT = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_unidades,
  input  logic [3:0] load_decenas,
  output logic [3:0] segundos_unidades,
  output logic [3:0] segundos_decenas,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  localparam int         DIV         = CLK_HZ / TICK_HZ;
  localparam bcd_digit_t C_MAX_UNITS = 4'(MAX_COUNT % 10);
  localparam bcd_digit_t C_MAX_TENS  = 4'(MAX_COUNT / 10);
  localparam logic [7:0] C_MAX_VAL   = 8'(MAX_COUNT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_start_stop_q;
  logic       r_running;
  logic       r_tick;
  logic       r_wrap;
  bcd_digit_t r_units;
  bcd_digit_t r_tens;

  logic       w_se;
  logic       w_tc;
  logic       w_pre_en;
  logic       w_pre_clr;
  logic       w_auto_stop;
  logic       w_step_wrap;
  bcd_digit_t w_step_units;
  bcd_digit_t w_step_tens;
  logic       w_load_bad;
  bcd_digit_t w_load_units;
  bcd_digit_t w_load_tens;

  assign w_se      = start_stop & ~r_start_stop_q;
  assign w_pre_en  = (r_state == RUNNING);
  assign w_pre_clr = clear | load | (r_state == IDLE);

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (w_pre_en),
    .clear  (w_pre_clr),
    .tick   (w_tc)
  );

  // Next digit pair for one count step in the current direction.
  always_comb begin
    w_step_units = r_units;
    w_step_tens  = r_tens;
    w_step_wrap  = 1'b0;
    if (!dir) begin
      if (r_tens == C_MAX_TENS && r_units == C_MAX_UNITS) begin
        w_step_units = 4'd0;
        w_step_tens  = 4'd0;
        w_step_wrap  = 1'b1;
      end else if (r_units == BCD_MAX_DIGIT) begin
        w_step_units = 4'd0;
        w_step_tens  = r_tens + 4'd1;
      end else begin
        w_step_units = r_units + 4'd1;
      end
    end else begin
      if (r_tens == 4'd0 && r_units == 4'd0) begin
        w_step_units = C_MAX_UNITS;
        w_step_tens  = C_MAX_TENS;
        w_step_wrap  = 1'b1;
      end else if (r_units == 4'd0) begin
        w_step_units = BCD_MAX_DIGIT;
        w_step_tens  = r_tens - 4'd1;
      end else begin
        w_step_units = r_units - 4'd1;
      end
    end
  end

`ifdef BCD_SECONDS_AUTO_STOP_EN
  assign w_auto_stop = dir & (r_tens == 4'd0) & (r_units == 4'd1);
`else
  assign w_auto_stop = 1'b0;
`endif

  assign w_load_bad   = (load_unidades > BCD_MAX_DIGIT) || (load_decenas > BCD_MAX_DIGIT) ||
                        (bcd_value(load_decenas, load_unidades) > C_MAX_VAL);
  assign w_load_units = w_load_bad ? C_MAX_UNITS : load_unidades;
  assign w_load_tens  = w_load_bad ? C_MAX_TENS  : load_decenas;

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else if (!load) begin
      if (w_se) begin
        case (r_state)
          IDLE:    w_state_nxt = RUNNING;
          RUNNING: w_state_nxt = PAUSED;
          PAUSED:  w_state_nxt = RUNNING;
          default: w_state_nxt = IDLE;
        endcase
      end
      if (w_tc && w_auto_stop) begin
        w_state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_start_stop_q <= 1'b0;
      r_running      <= 1'b0;
      r_tick         <= 1'b0;
      r_wrap         <= 1'b0;
      r_units        <= 4'd0;
      r_tens         <= 4'd0;
    end else begin
      r_start_stop_q <= start_stop;
      r_state        <= w_state_nxt;
      r_running      <= (w_state_nxt == RUNNING);
      r_tick         <= 1'b0;
      r_wrap         <= 1'b0;
      if (clear) begin
        r_units <= 4'd0;
        r_tens  <= 4'd0;
      end else if (load) begin
        r_units <= w_load_units;
        r_tens  <= w_load_tens;
      end else if (w_tc) begin
        r_units <= w_step_units;
        r_tens  <= w_step_tens;
        r_tick  <= 1'b1;
        r_wrap  <= w_step_wrap;
      end
    end
  end

  assign segundos_unidades = r_units;
  assign segundos_decenas  = r_tens;
  assign running           = r_running;
  assign tick              = r_tick;
  assign wrap              = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_bcd_seconds_counter.sv
// +----------------------------------------------------------------------+
// | tb_bcd_seconds_counter: directed self-checking bench, DIV = 10         |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bcd_seconds_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_unidades = 4'd0;
  logic [3:0] load_decenas = 4'd0;
  logic [3:0] segundos_unidades;
  logic [3:0] segundos_decenas;
  logic       running;
  logic       tick;
  logic       wrap;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  bcd_seconds_counter #(
    .CLK_HZ    (10),
    .TICK_HZ   (1),
    .MAX_COUNT (59)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start_stop        (start_stop),
    .clear             (clear),
    .dir               (dir),
    .load              (load),
    .load_unidades     (load_unidades),
    .load_decenas      (load_decenas),
    .segundos_unidades (segundos_unidades),
    .segundos_decenas  (segundos_decenas),
    .running           (running),
    .tick              (tick),
    .wrap              (wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] digits();
    return {24'd0, segundos_decenas, segundos_unidades};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press();
    start_stop = 1'b1;
    cyc(1);
    start_stop = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] u);
    load          = 1'b1;
    load_decenas  = t;
    load_unidades = u;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic wait_tick(input int max_cyc, output int c);
    c = 0;
    do begin
      cyc(1);
      c++;
    end while (!tick && c < max_cyc);
    check("tick_seen", {31'd0, tick}, 32'd1);
  endtask

  task automatic count_ticks(input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (tick) hits++;
    end
  endtask

  initial begin
    int c;
    int total;
    int hits;

    cyc(3);
    check("rst_digits",  digits(), 32'h00);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_tick",    {31'd0, tick}, 32'd0);
    check("rst_wrap",    {31'd0, wrap}, 32'd0);
    rst = 1'b0;
    cyc(1);

    press();
    check("se_running", {31'd0, running}, 32'd1);
    wait_tick(20, c);
    check("first_tick_latency", c, 32'd10);
    check("first_tick_digits", digits(), 32'h01);

    total = 0;
    for (int i = 0; i < 58; i++) begin
      wait_tick(20, c);
      total += c;
    end
    check("up_58_cycles", total, 32'd580);
    check("up_at_59", digits(), 32'h59);
    wait_tick(20, c);
    check("up_wrap_digits", digits(), 32'h00);
    check("up_wrap_pulse", {31'd0, wrap}, 32'd1);
    cyc(1);
    check("up_wrap_one_cycle", {31'd0, wrap}, 32'd0);
    check("tick_one_cycle", {31'd0, tick}, 32'd0);

    dir = 1'b1;
    wait_tick(20, c);
    check("down_wrap_digits", digits(), 32'h59);
    check("down_wrap_pulse", {31'd0, wrap}, 32'd1);
    do_load(4'd1, 4'd0);
    check("load_10", digits(), 32'h10);
    wait_tick(20, c);
    check("load_restarts_prescaler", c, 32'd10);
    check("down_borrow", digits(), 32'h09);

    dir = 1'b0;
    cyc(3);
    press();
    check("paused_running", {31'd0, running}, 32'd0);
    count_ticks(20, hits);
    check("paused_no_tick", hits, 32'd0);
    check("paused_hold", digits(), 32'h09);
    press();
    check("resume_running", {31'd0, running}, 32'd1);
    wait_tick(20, c);
    check("resume_latency", c, 32'd6);
    check("up_carry", digits(), 32'h10);

    do_load(4'd4, 4'd2);
    check("load_42", digits(), 32'h42);
    check("load_keeps_state", {31'd0, running}, 32'd1);
    do_load(4'd7, 4'd0);
    check("clamp_70", digits(), 32'h59);
    do_load(4'd1, 4'd1);
    check("load_11", digits(), 32'h11);
    do_load(4'd0, 4'd12);
    check("clamp_0_12", digits(), 32'h59);
    count_ticks(9, hits);
    check("pre_tc_no_tick", hits, 32'd0);
    do_load(4'd4, 4'd2);
    check("load_at_tc_digits", digits(), 32'h42);
    check("load_at_tc_no_tick", {31'd0, tick}, 32'd0);
    wait_tick(20, c);
    check("after_tc_load_latency", c, 32'd10);
    check("after_tc_load_step", digits(), 32'h43);

    do_load(4'd3, 4'd7);
    cyc(5);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("clear_digits", digits(), 32'h00);
    check("clear_running", {31'd0, running}, 32'd0);
    check("clear_tick", {31'd0, tick}, 32'd0);
    check("clear_wrap", {31'd0, wrap}, 32'd0);
    count_ticks(15, hits);
    check("idle_no_tick", hits, 32'd0);

    press();
    dir = 1'b1;
    do_load(4'd0, 4'd2);
    check("load_02", digits(), 32'h02);
    wait_tick(20, c);
    check("down_01", digits(), 32'h01);
    wait_tick(20, c);
    check("down_00", digits(), 32'h00);
    check("down_00_no_wrap", {31'd0, wrap}, 32'd0);
`ifdef BCD_SECONDS_AUTO_STOP_EN
    check("auto_stop_idle", {31'd0, running}, 32'd0);
    count_ticks(15, hits);
    check("auto_stop_hold", hits, 32'd0);
    press();
`else
    check("no_auto_stop", {31'd0, running}, 32'd1);
`endif
    wait_tick(20, c);
    check("down_restart_wrap_digits", digits(), 32'h59);
    check("down_restart_wrap", {31'd0, wrap}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
